// File: rtl/rtype_exec_stage.sv
// rtype_exec_stage
//   Execute stage fed by the R-type control decoder. ALU ops and zero-amount
//   shifts produce a registered result one cycle after acceptance. SLL/SRL/SRA
//   with a non-zero amount run on an iterative shifter that moves one bit per
//   cycle. Valid/ready handshakes on both sides. At most one op is in flight.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  input handshake. The op is captured when both are high.
//   ctrl                 op code: 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR,
//                        7 SRL, 8 SRA, 9 OR, 10 AND. Any other value is illegal.
//   rs1_data, rs2_data   operands. The shift amount is rs2_data[SHAMT_WIDTH-1:0].
//   rd_addr              destination register index
//   out_valid/out_ready  output handshake
//   result, out_rd_addr  result and its destination index
//   illegal              the accepted op code was outside 1..10
//
// state  | meaning
// IDLE   | no op held, ready for input
// SHIFT  | iterative shift in progress, input stalled
// DONE   | result presented, waiting for out_ready
module rtype_exec_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WIDTH     = 7,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SHAMT_WIDTH    = $clog2(DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_WIDTH-1:0]     ctrl,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      illegal
);

  localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL  = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT  = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_SLTU = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR  = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL  = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(10);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

  state_t                    r_state, w_state_nxt;
  kind_t                     r_kind, w_kind;
  logic [DATA_WIDTH-1:0]     r_work;
  logic [SHAMT_WIDTH-1:0]    r_count;
  logic [DATA_WIDTH-1:0]     r_result;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_illegal;

  logic                      w_accept;
  logic [SHAMT_WIDTH-1:0]    w_shamt;
  logic                      w_is_shift;
  logic                      w_start_shift;
  logic [DATA_WIDTH-1:0]     w_alu;
  logic                      w_illegal;
  logic                      w_lt_s;
  logic                      w_lt_u;
  logic [DATA_WIDTH-1:0]     w_step;

  assign in_ready      = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept      = in_valid & in_ready;
  assign w_shamt       = rs2_data[SHAMT_WIDTH-1:0];
  assign w_is_shift    = (ctrl == OP_SLL) | (ctrl == OP_SRL) | (ctrl == OP_SRA);
  // A zero-amount shift bypasses the shifter and finishes in one cycle like an ALU op.
  assign w_start_shift = w_is_shift & (w_shamt != '0);
  assign w_lt_s        = $signed(rs1_data) < $signed(rs2_data);
  assign w_lt_u        = rs1_data < rs2_data;

  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (ctrl)
      OP_ADD:                 w_alu = rs1_data + rs2_data;
      OP_SUB:                 w_alu = rs1_data - rs2_data;
      OP_SLT:                 w_alu = {{(DATA_WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTU:                w_alu = {{(DATA_WIDTH-1){1'b0}}, w_lt_u};
      OP_XOR:                 w_alu = rs1_data ^ rs2_data;
      OP_OR:                  w_alu = rs1_data | rs2_data;
      OP_AND:                 w_alu = rs1_data & rs2_data;
      OP_SLL, OP_SRL, OP_SRA: w_alu = rs1_data;
      default:                w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_kind = K_SLL;
    if (ctrl == OP_SRL) w_kind = K_SRL;
    else if (ctrl == OP_SRA) w_kind = K_SRA;
  end

  always_comb begin
    w_step = {r_work[DATA_WIDTH-2:0], 1'b0};
    case (r_kind)
      K_SRL:   w_step = {1'b0, r_work[DATA_WIDTH-1:1]};
      K_SRA:   w_step = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
      default: w_step = {r_work[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        // The last shift happens on the cycle the count drops from 1 to 0.
        if (r_count == SHAMT_WIDTH'(1)) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_kind    <= K_SLL;
      r_work    <= '0;
      r_count   <= '0;
      r_result  <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rd      <= rd_addr;
        r_illegal <= w_illegal;
        if (w_start_shift) begin
          r_work  <= rs1_data;
          r_count <= w_shamt;
          r_kind  <= w_kind;
        end else begin
          r_result <= w_alu;
          r_count  <= '0;
        end
      end else if (r_state == S_SHIFT) begin
        r_work  <= w_step;
        r_count <= r_count - SHAMT_WIDTH'(1);
        if (r_count == SHAMT_WIDTH'(1)) r_result <= w_step;
      end
    end
  end

  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign out_rd_addr = r_rd;
  assign illegal     = r_illegal;

endmodule
